// File: rtl/spi_tx.sv
// Byte-to-serial transmitter: a small FIFO feeding an MSB-first shifter.
// Words go out back-to-back; bit_valid marks live bits on bit_out.
module spi_tx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  input  logic                       flush,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_bit_out, r_bit_valid;
  logic             w_push, w_pop, w_last;
  logic [WIDTH-1:0] w_head;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign data_ready = rst_b & ~flush & (r_level != FULL_LVL);
  assign w_push     = data_valid & data_ready;
  assign w_head     = r_mem[r_rptr];
  assign bit_out    = r_bit_out;
  assign bit_valid  = r_bit_valid;
  assign level      = r_level;
  assign busy       = (r_state == SHIFT) | (r_level != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST_BIT) begin
          w_last = 1'b1;
          if (r_level != '0) w_pop       = 1'b1;
          else               w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b || flush) r_state <= IDLE;
    else                 r_state <= w_state_nxt;
  end

  // Storage needs no reset; w_push is already gated by reset and flush.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_b || flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_pop) begin
        r_shift     <= w_head;
        r_bit_out   <= w_head[WIDTH-1];
        r_bit_valid <= 1'b1;
        r_cnt       <= '0;
      end else if (w_last) begin
        r_bit_out   <= 1'b0;
        r_bit_valid <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
        r_bit_out <= r_shift[WIDTH-2];
        r_cnt     <= r_cnt + 1'b1;
      end
    end
  end
endmodule
